// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial adder sequencer: FSM state encoding and
// helpers that derive the slice-step count and counter width from WIDTH.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int steps(input int width);
        return width / 2;
    endfunction

    // One spare bit so the counter can represent N itself after the last step
    function automatic int countWidth(input int width);
        return $clog2(width / 2) + 1;
    endfunction

endpackage

// File: rtl/serial_add_sequencer_if.sv
// Requester-side bundle of the serial adder: start/operand request and
// busy/done/result response.
interface serial_add_sequencer_if #(
    parameter int WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);

endinterface

// File: rtl/two_bit_full_adder.sv
// Existing combinational two-bit adder slice shared by the sequencer.
module two_bit_full_adder (
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic       Cin,
    output logic [1:0] S,
    output logic       Cout
);

    assign {Cout, S} = {1'b0, A} + {1'b0, B} + {2'b00, Cin};

endmodule

// File: rtl/serial_add_sequencer.sv
// Computes {cout, sum} = a + b + cin two bits per cycle through one shared
// two-bit adder slice, with registered busy/done/result outputs.
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    serial_add_sequencer_if.slave  bus
);

    import serial_add_pkg::*;

    localparam int N  = steps(WIDTH);
    localparam int CW = countWidth(WIDTH);

    state_t           state;
    state_t           stateNext;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] accNext;
    logic             carry;
    logic [1:0]       sliceSum;
    logic             sliceCout;
    logic             lastStep;

    two_bit_full_adder slice (
        .A    (opA[1:0]),
        .B    (opB[1:0]),
        .Cin  (carry),
        .S    (sliceSum),
        .Cout (sliceCout)
    );

    assign lastStep = (count == CW'(N - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // The unused encoding falls through to the default and recovers to IDLE
    always_comb begin
        stateNext = ST_IDLE;
        case (state)
            ST_IDLE: stateNext = bus.start ? ST_RUN : ST_IDLE;
            ST_RUN:  stateNext = lastStep ? ST_DONE : ST_RUN;
            ST_DONE: stateNext = bus.start ? ST_RUN : ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    always_comb begin
        accNext = acc;
        for (int i = 0; i < N; i++) begin
            if (count == CW'(i)) begin
                accNext[2*i +: 2] = sliceSum;
            end
        end
    end

    // Operands are only reloaded outside RUN, so a start during RUN is dropped
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opA      <= '0;
            opB      <= '0;
            carry    <= 1'b0;
            count    <= '0;
            acc      <= '0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.busy <= (stateNext == ST_RUN);
            bus.done <= (stateNext == ST_DONE);
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        opA   <= bus.a;
                        opB   <= bus.b;
                        carry <= bus.cin;
                        count <= '0;
                        acc   <= '0;
                    end
                end
                ST_RUN: begin
                    acc   <= accNext;
                    carry <= sliceCout;
                    opA   <= opA >> 2;
                    opB   <= opB >> 2;
                    count <= count + CW'(1);
                    if (lastStep) begin
                        bus.sum  <= accNext;
                        bus.cout <= sliceCout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer: WIDTH=8 scenarios with
// hand-computed results plus an exhaustive WIDTH=4 sweep.
module tb_serial_add_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    serial_add_sequencer_if #(.WIDTH(8)) bus8 ();
    serial_add_sequencer_if #(.WIDTH(4)) bus4 ();

    serial_add_sequencer #(.WIDTH(8)) dut8 (
        .clock (clock),
        .reset (reset),
        .bus   (bus8.slave)
    );

    serial_add_sequencer #(.WIDTH(4)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4.slave)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin);
        bus8.a     = a;
        bus8.b     = b;
        bus8.cin   = cin;
        bus8.start = 1'b1;
    endtask

    // One pulsed operation: 4 busy cycles, a single done cycle, then hold
    task automatic runOp8(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [7:0] expSum, input logic expCout);
        applyStimulus(a, b, cin);
        cycle();
        bus8.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cycle();
            checkOutput({tag, "_busy"}, {bus8.busy, bus8.done}, 32'h2);
        end
        cycle();
        checkOutput({tag, "_done"}, {bus8.busy, bus8.done}, 32'h1);
        checkOutput({tag, "_result"}, {bus8.cout, bus8.sum}, {expCout, expSum});
        cycle();
        checkOutput({tag, "_pulse"}, {bus8.busy, bus8.done}, 32'h0);
        checkOutput({tag, "_hold"}, {bus8.cout, bus8.sum}, {expCout, expSum});
    endtask

    initial begin
        int          doneCount;
        logic        found;
        logic [4:0]  prev4;
        logic [4:0]  exp4;

        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus8.cin   = 1'b0;
        bus4.start = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;
        bus4.cin   = 1'b0;

        #12;
        checkOutput("reset_flags", {bus8.busy, bus8.done}, 32'h0);
        checkOutput("reset_result", {bus8.cout, bus8.sum}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        runOp8("carry_prop", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        runOp8("carry_in", 8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0);
        runOp8("cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

        // A second start two cycles into RUN must neither queue nor disturb
        applyStimulus(8'h10, 8'h20, 1'b0);
        cycle();
        bus8.start = 1'b0;
        cycle();
        cycle();
        applyStimulus(8'hAA, 8'hAA, 1'b0);
        cycle();
        bus8.start = 1'b0;
        checkOutput("ignore_busy", {bus8.busy, bus8.done}, 32'h2);
        cycle();
        checkOutput("ignore_done", {bus8.busy, bus8.done}, 32'h1);
        checkOutput("ignore_result", {bus8.cout, bus8.sum}, 32'h030);
        doneCount = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (bus8.done) doneCount++;
        end
        checkOutput("ignore_no_second_done", doneCount, 32'd0);
        checkOutput("ignore_hold", {bus8.cout, bus8.sum}, 32'h030);

        applyStimulus(8'h80, 8'h80, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            if (bus8.done) found = 1'b1;
        end
        checkOutput("b2b_first_done", found, 32'h1);
        checkOutput("b2b_first_result", {bus8.cout, bus8.sum}, 32'h100);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                cycle();
                checkOutput($sformatf("b2b_run%0d_busy%0d", r, i), {bus8.busy, bus8.done}, 32'h2);
            end
            cycle();
            checkOutput($sformatf("b2b_done%0d", r), {bus8.busy, bus8.done}, 32'h1);
            checkOutput($sformatf("b2b_result%0d", r), {bus8.cout, bus8.sum}, 32'h100);
        end
        bus8.start = 1'b0;
        cycle();
        checkOutput("b2b_stop", {bus8.busy, bus8.done}, 32'h0);

        runOp8("pre_reset", 8'hF0, 8'h20, 1'b1, 8'h11, 1'b1);

        // Reset lands between edges during slice step 2
        applyStimulus(8'h77, 8'h11, 1'b0);
        cycle();
        bus8.start = 1'b0;
        cycle();
        cycle();
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_flags", {bus8.busy, bus8.done}, 32'h0);
        checkOutput("async_reset_result", {bus8.cout, bus8.sum}, 32'h0);
        cycle();
        @(negedge clock);
        reset = 1'b0;
        runOp8("post_reset", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

        prev4 = 5'd0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    exp4 = 5'(a) + 5'(b) + 5'(c);
                    bus4.a     = 4'(a);
                    bus4.b     = 4'(b);
                    bus4.cin   = 1'(c);
                    bus4.start = 1'b1;
                    cycle();
                    bus4.start = 1'b0;
                    checkOutput("w4_busy", {bus4.busy, bus4.done}, 32'h2);
                    checkOutput("w4_hold", {bus4.cout, bus4.sum}, prev4);
                    cycle();
                    checkOutput("w4_hold2", {bus4.cout, bus4.sum}, prev4);
                    cycle();
                    checkOutput("w4_done", {bus4.busy, bus4.done}, 32'h1);
                    checkOutput($sformatf("w4_sum_a%0d_b%0d_c%0d", a, b, c),
                                {bus4.cout, bus4.sum}, exp4);
                    prev4 = exp4;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_add_sequencer.md
# serial_add_sequencer

Multi-cycle sequencer that performs a WIDTH-bit add (A + B + Cin) using a single shared two-bit full-adder slice. Each RUN cycle feeds the slice the next two operand bits and the registered carry. It sits between a requester issuing start/operand pulses and the two-bit adder datapath, reusing one small adder instead of a WIDTH-bit ripple chain.

## Interface
Parameters:
- WIDTH, 8, operand/result width; must be even and ≥ 2. N = WIDTH/2 slice steps per operation.

Ports:
- clock  input  1  single system clock, rising-edge active
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  request; sampled on a clock edge only in IDLE or DONE
- a  input  WIDTH  operand A, captured on the accepting edge
- b  input  WIDTH  operand B, captured on the accepting edge
- cin  input  1  carry-in, captured on the accepting edge
- busy  output  1  high while an operation is in progress (RUN)
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle on
- sum  output  WIDTH  registered result; holds until the next done
- cout  output  1  registered carry-out; holds until the next done

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN: latch a, b and cin into shift registers, clear the step counter.
  - RUN: on each edge, apply op slice bits [1:0] and the carry register to the adder. Write S into the accumulator at bit position 2*count, load the carry register from Cout, shift the operands right by 2, and increment count.
  - RUN → DONE on the edge that completes step N-1: copy the accumulator to sum and the final carry to cout.
  - DONE --start--> RUN: new operation, back-to-back. DONE --!start--> IDLE.
- start while in RUN is ignored, not queued. Operands and sum are unaffected.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- Reset (any time, including mid-RUN):
  - state = IDLE, busy = 0, done = 0, sum = 0, cout = 0.
  - Counter, carry register and accumulator clear to 0.
  - The partial result is discarded, and the pending operation is not resumed.
- sum and cout change only on the RUN→DONE edge or on reset. Partial results are never visible on the outputs.

## Timing
- Accepting edge k, where start = 1 in IDLE or DONE:
  - busy = 1 from after edge k through the cycle before edge k+N.
  - Slices 0..N-1 are computed on edges k+1..k+N.
  - done = 1 for exactly one cycle after edge k+N. busy = 0 in that cycle.
- Latency from start sampled to done asserted is N cycles (4 for WIDTH=8).
- Throughput with start held high: one result every N+1 cycles.
- Outputs are registered. No combinational path from start, a, b or cin to any output.
- Counter width: $clog2(N)+1 bits. It wraps only through the reset/clear on acceptance.
- Reset deassertion: the first edge after deassertion behaves as an IDLE edge, so start may be accepted on it.

## Structure
- Shared package, serial_add_pkg:
  - State encoding constants: ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2. Encoding 2'd3 is illegal and decodes to IDLE.
  - A localparam helper for the N and count-width derivation.
- One sub-module instance: two_bit_full_adder (ports A[1:0], B[1:0], Cin, S[1:0], Cout), the existing slice. It is purely combinational and has no clock.
- Sequencer body: FSM, step counter, operand shift registers, carry register, accumulator, output registers.

## Test plan
All scenarios use WIDTH=8 unless noted.
- Carry propagation: a=0xFF, b=0x01, cin=0, start pulsed → done exactly 4 cycles later with sum=0x00, cout=1. busy high for 4 cycles, done high for 1 cycle.
- Carry-in: a=0x5A, b=0x33, cin=1 → sum=0x8E, cout=0. Separately, a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
- Start during busy: start an op with a=0x10, b=0x20, then pulse start two cycles later with a=0xAA, b=0xAA → done once with sum=0x30, cout=0. No second done follows.
- Back-to-back: hold start high with a=0x80, b=0x80, cin=0 → done every 5 cycles, each with sum=0x00, cout=1. busy is 0 only in the done cycles.
- Reset mid-operation: assert reset asynchronously (between edges) during RUN step 2 → busy, done, sum and cout go to 0 without waiting for an edge. After release, a new start with a=0x01, b=0x02 → sum=0x03 after 4 cycles.
- Exhaustive at WIDTH=4: all 512 combinations of (a, b, cin), each compared against a + b + cin. Also check that sum/cout hold steady between done pulses.
